// File: rtl/keypad_lock_ctrl.sv
// Keypad lock sequencer: edge-detects encoder keys, buffers four BCD digits,
// compares them against a stored passcode, and handles lockout and reprogramming.
module keypad_lock_ctrl #(
    parameter logic [15:0] RESET_CODE  = 16'h1234,
    parameter int          MAX_TRIES   = 3,
    parameter int          LOCK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  key_code,
    input  logic        mode,
    input  logic        clr,
    output logic [15:0] code_buf,
    output logic [2:0]  count,
    output logic        unlocked,
    output logic        fail,
    output logic        locked,
    output logic        prog_done
);

    localparam int         TW    = $clog2(LOCK_CYCLES + 1);
    localparam logic [2:0] MAX_T = 3'(MAX_TRIES);

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        OPEN,
        PROG,
        LOCKOUT
    } state_t;

    state_t          state_reg;
    logic [15:0]     code_buf_reg;
    logic [2:0]      count_reg;
    logic            unlocked_reg;
    logic            fail_reg;
    logic            locked_reg;
    logic            prog_done_reg;
    logic [15:0]     stored_code_reg;
    logic [2:0]      tries_reg;
    logic [TW-1:0]   lock_timer_reg;
    logic            prev_valid_reg;

    logic            key_edge;
    logic            digit_ok;
    logic            key_accept;
    logic [15:0]     shifted_buf;
    logic [2:0]      count_inc;
    logic [2:0]      tries_inc;

    always_comb begin
        key_edge    = key_code[4] & ~prev_valid_reg;
        digit_ok    = (key_code[3:0] <= 4'd9);
        // Non-BCD edges still consume the press (prev_valid tracks them) but never shift.
        key_accept  = key_edge & digit_ok & (count_reg < 3'd4);
        shifted_buf = {code_buf_reg[11:0], key_code[3:0]};
        count_inc   = count_reg + 3'd1;
        tries_inc   = (tries_reg < MAX_T) ? tries_reg + 3'd1 : tries_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            code_buf_reg    <= 16'h0000;
            count_reg       <= 3'd0;
            unlocked_reg    <= 1'b0;
            fail_reg        <= 1'b0;
            locked_reg      <= 1'b0;
            prog_done_reg   <= 1'b0;
            stored_code_reg <= RESET_CODE;
            tries_reg       <= 3'd0;
            lock_timer_reg  <= '0;
            prev_valid_reg  <= 1'b0;
        end else begin
            prev_valid_reg <= key_code[4];
            fail_reg       <= 1'b0;
            prog_done_reg  <= 1'b0;

            case (state_reg)
                IDLE, ENTRY: begin
                    if (clr) begin
                        state_reg    <= IDLE;
                        code_buf_reg <= 16'h0000;
                        count_reg    <= 3'd0;
                    end else if (key_accept) begin
                        code_buf_reg <= shifted_buf;
                        count_reg    <= count_inc;
                        state_reg    <= (count_reg == 3'd3) ? CHECK : ENTRY;
                    end
                end

                CHECK: begin
                    code_buf_reg <= 16'h0000;
                    count_reg    <= 3'd0;
                    if (code_buf_reg == stored_code_reg) begin
                        state_reg    <= OPEN;
                        unlocked_reg <= 1'b1;
                        tries_reg    <= 3'd0;
                    end else begin
                        fail_reg  <= 1'b1;
                        tries_reg <= tries_inc;
                        if (tries_inc >= MAX_T) begin
                            state_reg      <= LOCKOUT;
                            locked_reg     <= 1'b1;
                            lock_timer_reg <= TW'(LOCK_CYCLES);
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end

                OPEN: begin
                    if (clr) begin
                        state_reg    <= IDLE;
                        unlocked_reg <= 1'b0;
                        code_buf_reg <= 16'h0000;
                        count_reg    <= 3'd0;
                    end else if (mode && key_accept) begin
                        // mode is sampled per key, so digits typed with mode low are simply dropped
                        code_buf_reg <= shifted_buf;
                        count_reg    <= count_inc;
                        if (count_reg == 3'd3) begin
                            state_reg <= PROG;
                        end
                    end
                end

                PROG: begin
                    stored_code_reg <= code_buf_reg;
                    prog_done_reg   <= 1'b1;
                    state_reg       <= IDLE;
                    unlocked_reg    <= 1'b0;
                    code_buf_reg    <= 16'h0000;
                    count_reg       <= 3'd0;
                end

                LOCKOUT: begin
                    if (lock_timer_reg <= TW'(1)) begin
                        state_reg      <= IDLE;
                        locked_reg     <= 1'b0;
                        tries_reg      <= 3'd0;
                        lock_timer_reg <= '0;
                    end else begin
                        lock_timer_reg <= lock_timer_reg - TW'(1);
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign code_buf  = code_buf_reg;
    assign count     = count_reg;
    assign unlocked  = unlocked_reg;
    assign fail      = fail_reg;
    assign locked    = locked_reg;
    assign prog_done = prog_done_reg;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Directed bench for keypad_lock_ctrl: unlock, held/invalid keys, clr, lockout,
// reprogramming and async reset, with hand-computed expectations.
module tb_keypad_lock_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  key_code;
    logic        mode;
    logic        clr;
    logic [15:0] code_buf;
    logic [2:0]  count;
    logic        unlocked;
    logic        fail;
    logic        locked;
    logic        prog_done;

    int checks;
    int failures;
    int fail_pulses;
    logic [2:0]  seen_count;
    logic [15:0] seen_buf;

    keypad_lock_ctrl #(
        .RESET_CODE (16'h1234),
        .MAX_TRIES  (3),
        .LOCK_CYCLES(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_code (key_code),
        .mode     (mode),
        .clr      (clr),
        .code_buf (code_buf),
        .count    (count),
        .unlocked (unlocked),
        .fail     (fail),
        .locked   (locked),
        .prog_done(prog_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fail === 1'b1) fail_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Key held valid for two cycles, then low; returns at the negedge where the
    // check result of a 4th digit is visible. Snapshot taken one cycle after the edge.
    task automatic press(input logic [3:0] d);
        @(negedge clk);
        key_code = {1'b1, d};
        @(negedge clk);
        seen_count = count;
        seen_buf   = code_buf;
        @(negedge clk);
        key_code = 5'd0;
        $display("key %0d: count=%0d code_buf=%h unlocked=%b fail=%b locked=%b",
                 d, seen_count, seen_buf, unlocked, fail, locked);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        fail_pulses = 0;
        rst_n    = 1'b0;
        key_code = 5'd0;
        mode     = 1'b0;
        clr      = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_code_buf", code_buf, 16'h0000);
        check("rst_count", {13'd0, count}, 16'd0);
        check("rst_flags", {12'd0, unlocked, fail, locked, prog_done}, 16'd0);
        rst_n = 1'b1;

        // Unlock with the reset passcode
        press(4'd1); check("unlock_cnt1", {13'd0, seen_count}, 16'd1); check("unlock_buf1", seen_buf, 16'h0001);
        press(4'd2); check("unlock_cnt2", {13'd0, seen_count}, 16'd2); check("unlock_buf2", seen_buf, 16'h0012);
        press(4'd3); check("unlock_cnt3", {13'd0, seen_count}, 16'd3); check("unlock_buf3", seen_buf, 16'h0123);
        press(4'd4); check("unlock_cnt4", {13'd0, seen_count}, 16'd4); check("unlock_buf4", seen_buf, 16'h1234);
        check("unlock_open", {15'd0, unlocked}, 16'd1);
        check("unlock_cnt_clr", {13'd0, count}, 16'd0);
        #1 check("unlock_no_fail", 16'(fail_pulses), 16'd0);

        pulse_clr();
        check("clr_open_relock", {15'd0, unlocked}, 16'd0);
        $display("clr in OPEN: unlocked=%b", unlocked);

        // Held key accepted once, non-BCD digit ignored
        @(negedge clk);
        key_code = 5'b10111;
        repeat (10) @(negedge clk);
        key_code = 5'd0;
        check("held_count", {13'd0, count}, 16'd1);
        check("held_buf", code_buf, 16'h0007);
        @(negedge clk);
        key_code = 5'b11100;
        repeat (2) @(negedge clk);
        key_code = 5'd0;
        check("invalid_count", {13'd0, count}, 16'd1);
        check("invalid_buf", code_buf, 16'h0007);
        $display("held 7 then digit 12: count=%0d code_buf=%h", count, code_buf);
        pulse_clr();
        check("clr_entry_count", {13'd0, count}, 16'd0);

        // clr coincident with a key edge discards the digit
        press(4'd1);
        press(4'd2);
        @(negedge clk);
        key_code = 5'b10011;
        clr      = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_prec_count", {13'd0, count}, 16'd0);
        check("clr_prec_buf", code_buf, 16'h0000);
        @(negedge clk);
        key_code = 5'd0;
        check("clr_prec_held", {13'd0, count}, 16'd0);
        $display("clr with key 3: count=%0d code_buf=%h", count, code_buf);

        // Three wrong entries -> lockout
        for (int t = 1; t <= 3; t++) begin
            press(4'd9); press(4'd9); press(4'd9); press(4'd9);
            check("wrong_fail", {15'd0, fail}, 16'd1);
            check("wrong_locked", {15'd0, locked}, (t == 3) ? 16'd1 : 16'd0);
            check("wrong_unlocked", {15'd0, unlocked}, 16'd0);
        end
        #1 check("fail_pulse_total", 16'(fail_pulses), 16'd3);
        press(4'd1);
        check("lock_key_ignored", {13'd0, seen_count}, 16'd0);
        press(4'd2);
        check("lock_key_ignored2", {13'd0, seen_count}, 16'd0);
        repeat (9) @(negedge clk);
        check("lock_last_cycle", {15'd0, locked}, 16'd1);
        @(negedge clk);
        check("lock_released", {15'd0, locked}, 16'd0);
        $display("lockout released: locked=%b", locked);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check("post_lock_unlock", {15'd0, unlocked}, 16'd1);

        // Reprogram to 5678 from OPEN
        @(negedge clk);
        mode = 1'b1;
        press(4'd5); press(4'd6); press(4'd7); press(4'd8);
        check("prog_buf", seen_buf, 16'h5678);
        check("prog_done_pulse", {15'd0, prog_done}, 16'd1);
        check("prog_relock", {15'd0, unlocked}, 16'd0);
        mode = 1'b0;
        @(negedge clk);
        check("prog_done_single", {15'd0, prog_done}, 16'd0);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check("old_code_fails", {15'd0, fail}, 16'd1);
        check("old_code_locked", {15'd0, unlocked}, 16'd0);
        press(4'd5); press(4'd6); press(4'd7); press(4'd8);
        check("new_code_unlocks", {15'd0, unlocked}, 16'd1);
        press(4'd3);
        check("open_mode0_ignored", {13'd0, seen_count}, 16'd0);
        pulse_clr();

        // Async reset mid-entry reverts the stored code
        press(4'd4); press(4'd4);
        check("pre_reset_buf", code_buf, 16'h0044);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_buf", code_buf, 16'h0000);
        check("async_rst_count", {13'd0, count}, 16'd0);
        check("async_rst_flags", {12'd0, unlocked, fail, locked, prog_done}, 16'd0);
        $display("async reset mid-entry: count=%0d code_buf=%h", count, code_buf);
        @(negedge clk);
        rst_n = 1'b1;
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check("reset_code_restored", {15'd0, unlocked}, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
